// File: rtl/mem_pkg.sv
// Shared definitions for the memory port and the CPU controller that drives it.
package mem_pkg;

   localparam int ADDR_W = 9;
   localparam int DATA_W = 16;

   // mem_cmd encodings; 2'b11 is treated as no command
   localparam logic [1:0] MNONE  = 2'b00;
   localparam logic [1:0] MREAD  = 2'b01;
   localparam logic [1:0] MWRITE = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      DONE = 2'b10
   } acc_state_t;

   // True only for the two encodings that start a RAM transaction
   function automatic logic is_access(input logic [1:0] cmd);
      return (cmd == MREAD) || (cmd == MWRITE);
   endfunction

endpackage

// File: rtl/mem_port_hs.sv
// Memory access handshake: access FSM, registered RAM request, read data capture.
// Optional request timeout compiled in with MEM_PORT_TIMEOUT_EN.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | no access; a READ/WRITE command latches a request
//  REQ   | ram_req high, request fields frozen, waiting for ram_ack
//  DONE  | one bubble cycle, busy low, command ignored
module mem_port_hs
   import mem_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [1:0]        i_cmd,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [DATA_W-1:0] i_ram_rdata,
   input  logic              i_ram_ack,
   output logic              o_busy,
   output logic              o_err,
   output logic [DATA_W-1:0] o_mdata,
   output logic              o_ram_req,
   output logic              o_ram_we,
   output logic [ADDR_W-1:0] o_ram_addr,
   output logic [DATA_W-1:0] o_ram_wdata
);

   acc_state_t        r_state;
   acc_state_t        w_state_nxt;
   logic              w_issue;
   logic              w_capture;
   logic              w_abort;
   logic              w_tmo_hit;

   logic              r_ram_req;
   logic              r_ram_we;
   logic [ADDR_W-1:0] r_ram_addr;
   logic [DATA_W-1:0] r_ram_wdata;
   logic [DATA_W-1:0] r_mdata;

   // State register
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state, stall and datapath strobes; an ack wins over a same-cycle timeout
   always_comb begin
      w_state_nxt = r_state;
      o_busy      = 1'b0;
      w_issue     = 1'b0;
      w_capture   = 1'b0;
      w_abort     = 1'b0;
      case (r_state)
         IDLE: begin
            if (is_access(i_cmd)) begin
               o_busy      = 1'b1;
               w_issue     = 1'b1;
               w_state_nxt = REQ;
            end
         end
         REQ: begin
            o_busy = 1'b1;
            if (i_ram_ack) begin
               w_capture   = !r_ram_we;
               w_state_nxt = DONE;
            end else if (w_tmo_hit) begin
               w_abort     = 1'b1;
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Request fields are captured once at issue and stay frozen through REQ
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_ram_req   <= 1'b0;
         r_ram_we    <= 1'b0;
         r_ram_addr  <= '0;
         r_ram_wdata <= '0;
         r_mdata     <= '0;
      end else begin
         if (w_issue) begin
            r_ram_req   <= 1'b1;
            r_ram_we    <= (i_cmd == MWRITE);
            r_ram_addr  <= i_addr;
            r_ram_wdata <= i_wdata;
         end else if ((r_state == REQ) && (i_ram_ack || w_abort)) begin
            r_ram_req <= 1'b0;
         end
         if (w_capture) begin
            r_mdata <= i_ram_rdata;
         end
      end
   end

`ifdef MEM_PORT_TIMEOUT_EN
   localparam int TMR_W = $clog2(TIMEOUT + 1);

   logic [TMR_W-1:0] r_tmr;
   logic             r_err;

   // Down-counter loaded at issue; terminal count in REQ aborts the access
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_tmr <= '0;
         r_err <= 1'b0;
      end else begin
         if (w_issue) begin
            r_tmr <= TMR_W'(TIMEOUT - 1);
         end else if ((r_state == REQ) && (r_tmr != '0)) begin
            r_tmr <= r_tmr - TMR_W'(1);
         end
         if (w_abort) begin
            r_err <= 1'b1;
         end
      end
   end

   assign w_tmo_hit = (r_tmr == '0);
   assign o_err     = r_err;
`else
   // TIMEOUT has no effect in this build; REQ waits for the ack forever
   if (TIMEOUT < 1) begin : g_timeout_unused
   end

   assign w_tmo_hit = 1'b0;
   assign o_err     = 1'b0;
`endif

   assign o_mdata     = r_mdata;
   assign o_ram_req   = r_ram_req;
   assign o_ram_we    = r_ram_we;
   assign o_ram_addr  = r_ram_addr;
   assign o_ram_wdata = r_ram_wdata;

endmodule

// File: rtl/mem_port.sv
// Memory port stage below the CPU controller: PC, IR, data address and address mux,
// with the RAM handshake in mem_port_hs. MEM_PORT_TIMEOUT_EN enables the REQ timeout.
module mem_port
   import mem_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = 9'd0,
   parameter int                TIMEOUT  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_pc,
   input  logic              reset_pc,
   input  logic              load_ir,
   input  logic              addr_sel,
   input  logic              load_addr,
   input  logic [1:0]        mem_cmd,
   input  logic [DATA_W-1:0] datapath_out,
   output logic [ADDR_W-1:0] pc,
   output logic [DATA_W-1:0] ir,
   output logic [DATA_W-1:0] mdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              busy,
   output logic              err,
   output logic              ram_req,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   input  logic              ram_ack
);

   logic [ADDR_W-1:0] r_pc;
   logic [DATA_W-1:0] r_ir;
   logic [ADDR_W-1:0] r_data_addr;
   logic              w_busy;
   logic [DATA_W-1:0] w_mdata;

   // Program counter; reset_pc overrides load_pc, increment wraps at 512
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_pc <= RESET_PC;
      end else if (reset_pc) begin
         r_pc <= RESET_PC;
      end else if (load_pc) begin
         r_pc <= r_pc + 9'd1;
      end
   end

   // Data address and instruction register; IR only fetches once the access is over
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_data_addr <= '0;
         r_ir        <= '0;
      end else begin
         if (load_addr) begin
            r_data_addr <= datapath_out[ADDR_W-1:0];
         end
         if (load_ir && !w_busy) begin
            r_ir <= w_mdata;
         end
      end
   end

   assign mem_addr = addr_sel ? r_pc : r_data_addr;

   mem_port_hs #(
      .TIMEOUT (TIMEOUT)
   ) u_hs (
      .i_clk       (clk),
      .i_rst_n     (reset),
      .i_cmd       (mem_cmd),
      .i_addr      (mem_addr),
      .i_wdata     (datapath_out),
      .i_ram_rdata (ram_rdata),
      .i_ram_ack   (ram_ack),
      .o_busy      (w_busy),
      .o_err       (err),
      .o_mdata     (w_mdata),
      .o_ram_req   (ram_req),
      .o_ram_we    (ram_we),
      .o_ram_addr  (ram_addr),
      .o_ram_wdata (ram_wdata)
   );

   assign pc    = r_pc;
   assign ir    = r_ir;
   assign mdata = w_mdata;
   assign busy  = w_busy;

endmodule

// File: tb/tb_mem_port.sv
// Bench for mem_port: request scoreboard checked by a negedge monitor, access
// sequencing, PC wrap, timeout (when MEM_PORT_TIMEOUT_EN is defined) and reset abort.
module tb_mem_port;
   import mem_pkg::*;

   localparam logic [8:0] TB_RESET_PC = 9'd0;

   logic        clk = 1'b0;
   logic        reset;
   logic        load_pc, reset_pc, load_ir, addr_sel, load_addr;
   logic [1:0]  mem_cmd;
   logic [15:0] datapath_out;
   logic [8:0]  pc;
   logic [15:0] ir, mdata;
   logic [8:0]  mem_addr;
   logic        busy, err, ram_req, ram_we;
   logic [8:0]  ram_addr;
   logic [15:0] ram_wdata, ram_rdata;
   logic        ram_ack;

   mem_port #(.RESET_PC(TB_RESET_PC), .TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .load_pc(load_pc), .reset_pc(reset_pc),
      .load_ir(load_ir), .addr_sel(addr_sel), .load_addr(load_addr),
      .mem_cmd(mem_cmd), .datapath_out(datapath_out), .pc(pc), .ir(ir),
      .mdata(mdata), .mem_addr(mem_addr), .busy(busy), .err(err),
      .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ack(ram_ack)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [8:0]  addr;
      logic        we;
      logic [15:0] wd;
   } req_t;

   req_t        q_req[$];
   logic [15:0] q_rd[$];

   int n_vec  = 0;
   int n_miss = 0;

   logic [8:0]  m_pc, m_daddr;
   logic [15:0] m_ir, m_mdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Request monitor: pops the expected request on ram_req rise, then checks it stays frozen
   logic mon_prev = 1'b0;
   req_t mon_cur;
   always @(negedge clk) begin
      if (ram_req === 1'b1 && !mon_prev) begin
         if (q_req.size() == 0) begin
            chk("req_unexpected", 32'd1, 32'd0);
         end else begin
            mon_cur = q_req.pop_front();
            chk("req_addr", ram_addr, mon_cur.addr);
            chk("req_we", ram_we, mon_cur.we);
            chk("req_wdata", ram_wdata, mon_cur.wd);
         end
      end else if (ram_req === 1'b1 && mon_prev) begin
         chk("req_addr_hold", ram_addr, mon_cur.addr);
         chk("req_we_hold", ram_we, mon_cur.we);
         chk("req_wdata_hold", ram_wdata, mon_cur.wd);
      end
      mon_prev = (ram_req === 1'b1);
   end

   task automatic pulse_pc(input int n);
      load_pc = 1'b1;
      repeat (n) @(posedge clk);
      #1 load_pc = 1'b0;
      m_pc = m_pc + 9'(n);
   endtask

   // Runs one access from IDLE at posedge+1; ack_at = REQ cycle carrying the ack (0 = never)
   task automatic access(input logic [1:0] cmd, input logic sel, input logic [15:0] dout,
                         input int ack_at, input logic [15:0] rd, input int exp_busy,
                         input logic lir, input logic exp_tmo);
      req_t r;
      int   nb, rc;
      r.addr = sel ? m_pc : m_daddr;
      r.we   = (cmd == MWRITE);
      r.wd   = dout;
      q_req.push_back(r);
      if (cmd == MREAD && !exp_tmo) q_rd.push_back(rd);
      mem_cmd = cmd; addr_sel = sel; datapath_out = dout; load_ir = lir;
      #1;
      chk("issue_busy", busy, 1'b1);
      chk("issue_mem_addr", mem_addr, r.addr);
      nb = 1; rc = 0;
      for (int k = 0; k < 64; k++) begin
         @(posedge clk); #1;
         mem_cmd = MNONE; ram_ack = 1'b0;
         datapath_out = ~dout; addr_sel = ~sel;
         if (ram_req) begin
            rc++;
            if (rc == ack_at) begin
               ram_ack = 1'b1; ram_rdata = rd;
            end
         end
         if (!busy) break;
         nb++;
      end
      load_ir = 1'b0;
      chk("busy_cycles", nb, exp_busy);
      chk("done_req_low", ram_req, 1'b0);
      if (cmd == MREAD && !exp_tmo) begin
         if (q_rd.size() == 0) chk("rd_queue_empty", 32'd1, 32'd0);
         else m_mdata = q_rd.pop_front();
      end
      chk("done_mdata", mdata, m_mdata);
      chk("ir_hold", ir, m_ir);
      @(posedge clk); #1;
   endtask

   initial begin
      reset = 1'b0; load_pc = 0; reset_pc = 0; load_ir = 0; addr_sel = 0; load_addr = 0;
      mem_cmd = MNONE; datapath_out = '0; ram_rdata = '0; ram_ack = 1'b0;
      @(posedge clk); #1;
      chk("rst_pc", pc, TB_RESET_PC);
      chk("rst_ir", ir, 16'h0);
      chk("rst_mdata", mdata, 16'h0);
      chk("rst_ram_req", ram_req, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_err", err, 1'b0);
      reset = 1'b1;
      m_pc = TB_RESET_PC; m_daddr = '0; m_ir = '0; m_mdata = '0;

      pulse_pc(5);
      chk("pc_5", pc, m_pc);

      access(MREAD, 1'b1, 16'h0000, 1, 16'hD2A0, 2, 1'b0, 1'b0);
      load_ir = 1'b1; @(posedge clk); #1 load_ir = 1'b0;
      m_ir = m_mdata;
      chk("ir_fetch", ir, 16'hD2A0);

      datapath_out = 16'h0123; load_addr = 1'b1;
      @(posedge clk); #1 load_addr = 1'b0;
      m_daddr = 9'h123; addr_sel = 1'b0;
      #1 chk("mem_addr_data", mem_addr, 9'h123);
      access(MWRITE, 1'b0, 16'hBEEF, 4, 16'h5555, 5, 1'b0, 1'b0);

      access(MREAD, 1'b0, 16'h0000, 2, 16'h1357, 3, 1'b1, 1'b0);

      mem_cmd = 2'b11; #1 chk("cmd11_busy", busy, 1'b0);
      @(posedge clk); #1 chk("cmd11_req", ram_req, 1'b0);
      mem_cmd = MNONE;

`ifdef MEM_PORT_TIMEOUT_EN
      access(MREAD, 1'b1, 16'h0000, 0, 16'h0000, 17, 1'b0, 1'b1);
      chk("tmo_err", err, 1'b1);
      access(MREAD, 1'b1, 16'h0000, 1, 16'h2468, 2, 1'b0, 1'b0);
      chk("tmo_err_sticky", err, 1'b1);
`else
      access(MREAD, 1'b1, 16'h0000, 20, 16'h2468, 21, 1'b0, 1'b0);
      chk("no_tmo_err", err, 1'b0);
`endif

      pulse_pc(506);
      chk("pc_511", pc, 9'd511);
      pulse_pc(1);
      chk("pc_wrap", pc, 9'd0);
      pulse_pc(3);
      chk("pc_3", pc, m_pc);
      reset_pc = 1'b1; load_pc = 1'b1;
      @(posedge clk); #1 reset_pc = 1'b0; load_pc = 1'b0;
      m_pc = TB_RESET_PC;
      chk("pc_reset_prio", pc, m_pc);
      pulse_pc(2);

      begin
         req_t r;
         r.addr = m_pc; r.we = 1'b0; r.wd = 16'h00AA;
         q_req.push_back(r);
      end
      mem_cmd = MREAD; addr_sel = 1'b1; datapath_out = 16'h00AA;
      @(posedge clk); #1 mem_cmd = MNONE;
      chk("abort_req_high", ram_req, 1'b1);
      reset = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
      chk("abort_req_low", ram_req, 1'b0);
      ram_ack = 1'b1; ram_rdata = 16'hFFFF;
      @(posedge clk); #1 ram_ack = 1'b0;
      chk("abort_mdata", mdata, 16'h0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_req_still_low", ram_req, 1'b0);
      chk("abort_pc", pc, TB_RESET_PC);
      chk("abort_err", err, 1'b0);
      chk("req_queue_drained", q_req.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
